button_conditioner: RTL

- Front-end stage feeding the player controller's button_up / button_down inputs.
- Synchronises the two raw, asynchronous push-button pins into clk, debounces each one, and delivers:
  - button_down as a clean held level (used for ducking);
  - button_up as a sticky press flag, held until the next game_tick[0] consumes it, so a short press between ticks is never lost.

---
 rtl/button_conditioner_pkg.sv | 6 +
 rtl/button_debouncer.sv | 51 +++++
 rtl/button_conditioner.sv | 49 ++++
 3 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared defaults for the button front-end: debounce counter width and
// hardware debounce window (2 ms at 25 MHz).
package button_conditioner_pkg;
  localparam int CNT_W_DEF        = 16;
  localparam int DEBOUNCE_DEF     = 50000;
endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchroniser, symmetric counter debounce of the stable
// level, and a one-cycle pulse on the debounced rising edge.
module button_debouncer
  import button_conditioner_pkg::*;
#(
  parameter int CNT_W           = CNT_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d, level_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s;

  assign s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync_q      <= {sync_q[0], raw};
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
    end
  end

  // Threshold is checked before incrementing, so the counter never wraps;
  // any sample matching the stable level restarts the window.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (s != level_q) begin
      if (cnt_q == THRESH) level_d = s;
      else                 cnt_d   = cnt_q + 1'b1;
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~level_dly_q;
endmodule

// File: rtl/button_conditioner.sv
// Debounces up/down buttons; up becomes a sticky press flag held until the
// next input-sample tick consumes it, down is a plain debounced level.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int CNT_W           = CNT_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  input  logic [1:0] game_tick,
  output logic       button_up,
  output logic       button_down,
  output logic       up_level,
  output logic       up_press_pulse
);
  logic up_lvl, up_rise, dn_lvl, dn_rise_unused;
  logic pend_q, pend_d;
  logic tick_unused;

  assign tick_unused = game_tick[1];

  button_debouncer #(.CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .rst(rst), .raw(btn_up_raw), .level(up_lvl), .rise(up_rise)
  );

  button_debouncer #(.CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(clk), .rst(rst), .raw(btn_down_raw), .level(dn_lvl), .rise(dn_rise_unused)
  );

  // A fresh press wins over a coincident tick so it is never lost.
  always_comb begin
    pend_d = pend_q;
    if (up_rise)           pend_d = 1'b1;
    else if (game_tick[0]) pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= pend_d;
  end

  assign button_up      = pend_q;
  assign button_down    = dn_lvl;
  assign up_level       = up_lvl;
  assign up_press_pulse = up_rise;
endmodule
